wb_stage_reg: RTL and testbench
===============================

// Module: wb_stage_reg
// PURPOSE
//  Parametrised write-back stage that owns the MEM/WB pipeline register. Captures MEM-stage results,
//  extracts and extends load data, selects ALU/MEM/PC+4 and drives the register-file write port.
//  Supports stall and flush. Counts retired instructions. Sits between the memory stage and the register file.
// PARAMETERS
//  XLEN      32  datapath width; 32 or 64 only
//  RADDR_W   5   register address width
//  CNT_W     32  retire counter width; wraps modulo 2^CNT_W
// PORTS
//  i_clk            in   1        clock; all state changes on rising edge
//  i_rst            in   1        synchronous active-high reset
//  i_valid          in   1        MEM stage presents an instruction this cycle
//  i_stall          in   1        hold WB register contents
//  i_flush          in   1        load a bubble into the WB register
//  i_alu_result     in   XLEN     ALU result / effective address
//  i_read_data      in   XLEN     raw aligned data-memory word
//  i_pc_plus4       in   XLEN     link value for JAL/JALR
//  i_addr_lo        in   3        low effective-address bits; bit 2 is used only when XLEN=64
//  i_load_funct3    in   3        load type (RISC-V funct3 encoding)
//  i_wb_sel         in   2        00 ALU, 01 MEM, 10 PC+4, 11 reserved (treated as ALU)
//  i_rd             in   RADDR_W  destination register
//  i_reg_write      in   1        instruction writes rd
//  o_wb_data        out  XLEN     register-file write data
//  o_wb_rd          out  RADDR_W  register-file write address
//  o_wb_reg_write   out  1        register-file write enable
//  o_wb_valid       out  1        instruction retires this cycle (single-cycle pulse per instruction)
//  o_retire_count   out  CNT_W    number of retired instructions
// BEHAVIOUR
//  - Register update priority per edge: i_rst > i_flush > i_stall > capture.
//  - Reset: valid=0, fresh=0, all fields 0, o_retire_count=0. Outputs read o_wb_data=0, o_wb_rd=0,
//    o_wb_reg_write=0 and o_wb_valid=0 in the cycle after reset.
//  - Flush: valid=0 and fresh=0. Data fields are don't-care and are held.
//  - Stall: all fields are held and fresh is cleared. A held instruction does not write or count again.
//  - Capture: fields <= inputs, valid <= i_valid, fresh <= 1.
//  - Latency: inputs sampled at edge N appear on the outputs after edge N; o_wb_data is combinational
//    from the registered fields.
//  - o_wb_valid = valid & fresh.
//  - o_wb_reg_write = o_wb_valid & reg_write & (rd != 0). rd = x0 never writes.
//  - o_wb_rd = registered rd. o_wb_data = mux(wb_sel) of ALU, extended load and PC+4; 11 selects ALU.
//  - Load extract uses the registered addr_lo (lane) and funct3:
//      000 LB   sign-extend byte[lane]
//      100 LBU  zero-extend byte[lane]
//      001 LH   sign-extend half[lane>>1]; addr bit0 ignored
//      101 LHU  zero-extend half[lane>>1]; addr bit0 ignored
//      010 LW   sign-extend word[lane>>2]; full word when XLEN=32
//      110 LWU  zero-extend word[lane>>2]; same as LW when XLEN=32
//      011      full XLEN
//      111      full XLEN
//    For XLEN=32, addr_lo[2] is ignored.
//  - Retire counter: +1 on every edge where o_wb_valid=1 and i_rst=0. Wraps from all-ones to 0.
//    Reset overrides the increment in the same cycle.
//  - Flush and stall asserted together: the flush wins and a bubble is loaded. The instruction
//    currently in WB has already written and counted if it was fresh.
// STRUCTURE
//  - Package wb_pkg holds:
//      WB_SEL_ALU/MEM/PC4 localparams
//      LOAD_LB..LOAD_LWU funct3 constants
//  - Sub-module wb_load_ext: combinational lane select and sign/zero extend (XLEN, funct3, addr_lo, word).
//  - Top level holds the pipeline register, the fresh flag, the result mux, write gating and the counter.
// TESTING
//  - Reset mid-stream: valid ALU write, then i_rst for 1 cycle.
//    -> next cycle all outputs 0 and o_retire_count=0.
//  - LB, addr_lo=3, read_data=0x80FF_0000, wb_sel=01, rd=5.
//    -> o_wb_data=0xFFFF_FF80, write to x5, count+1.
//  - LHU, addr_lo=2, read_data=0xBEEF_1234.
//    -> o_wb_data=0x0000_BEEF.
//  - LH, addr_lo=3 (bit0 ignored), read_data=0x8001_0000.
//    -> 0xFFFF_8001.
//  - JAL, wb_sel=10, pc_plus4=0x104, rd=1.
//    -> o_wb_data=0x104.
//  - ALU write with rd=0.
//    -> o_wb_reg_write=0, o_wb_valid=1, count+1.
//  - Capture an instruction, then i_stall for 3 cycles.
//    -> o_wb_reg_write high only in the first cycle, count +1 total.
//  - i_flush with i_stall together.
//    -> bubble, no write, count unchanged.
//  - CNT_W=4, preload 15 retirements, then 1 more.
//    -> o_retire_count=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants for the write-back stage: result-select codes, load funct3 encodings, field widths.
package wb_pkg;

    localparam int unsigned WB_SEL_W  = 2;
    localparam int unsigned FUNCT3_W  = 3;
    localparam int unsigned ADDR_LO_W = 3;

    localparam logic [WB_SEL_W-1:0] WB_SEL_ALU = 2'b00;
    localparam logic [WB_SEL_W-1:0] WB_SEL_MEM = 2'b01;
    localparam logic [WB_SEL_W-1:0] WB_SEL_PC4 = 2'b10;

    localparam logic [FUNCT3_W-1:0] LOAD_LB  = 3'b000;
    localparam logic [FUNCT3_W-1:0] LOAD_LH  = 3'b001;
    localparam logic [FUNCT3_W-1:0] LOAD_LW  = 3'b010;
    localparam logic [FUNCT3_W-1:0] LOAD_LBU = 3'b100;
    localparam logic [FUNCT3_W-1:0] LOAD_LHU = 3'b101;
    localparam logic [FUNCT3_W-1:0] LOAD_LWU = 3'b110;

endpackage

// File: rtl/wb_load_ext.sv
// Load-data lane select and sign/zero extension from an aligned XLEN-wide memory word.
module wb_load_ext
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [FUNCT3_W-1:0]  funct3,
    input  logic [ADDR_LO_W-1:0] addr_lo,
    input  logic [XLEN-1:0]      word,
    output logic [XLEN-1:0]      data_c
);

    logic [ADDR_LO_W-1:0] lane;
    logic [7:0]           byte_v;
    logic [15:0]          half_v;
    logic [31:0]          word_v;

    // On a 32-bit datapath there is no upper word, so address bit 2 is forced to zero.
    always_comb begin
        lane   = (XLEN == 64) ? addr_lo : {1'b0, addr_lo[1:0]};
        byte_v = '0;
        half_v = '0;
        word_v = '0;
        for (int i = 0; i < int'(XLEN / 8); i++) begin
            if (lane == 3'(i)) byte_v = word[i*8 +: 8];
        end
        for (int i = 0; i < int'(XLEN / 16); i++) begin
            if (lane[2:1] == 2'(i)) half_v = word[i*16 +: 16];
        end
        for (int i = 0; i < int'(XLEN / 32); i++) begin
            if (lane[2] == 1'(i)) word_v = word[i*32 +: 32];
        end
    end

    always_comb begin
        data_c = word;
        case (funct3)
            LOAD_LB:  data_c = {{(XLEN-8){byte_v[7]}}, byte_v};
            LOAD_LBU: data_c = {{(XLEN-8){1'b0}}, byte_v};
            LOAD_LH:  data_c = {{(XLEN-16){half_v[15]}}, half_v};
            LOAD_LHU: data_c = {{(XLEN-16){1'b0}}, half_v};
            LOAD_LW:  data_c = XLEN'({{32{word_v[31]}}, word_v});
            LOAD_LWU: data_c = XLEN'({32'b0, word_v});
            default:  data_c = word;
        endcase
    end

endmodule

// File: rtl/wb_stage_reg.sv
// MEM/WB pipeline register with load extension, result select, register-file write gating
// and a retired-instruction counter.
module wb_stage_reg
    import wb_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    input  logic                 i_stall,
    input  logic                 i_flush,
    input  logic [XLEN-1:0]      i_alu_result,
    input  logic [XLEN-1:0]      i_read_data,
    input  logic [XLEN-1:0]      i_pc_plus4,
    input  logic [ADDR_LO_W-1:0] i_addr_lo,
    input  logic [FUNCT3_W-1:0]  i_load_funct3,
    input  logic [WB_SEL_W-1:0]  i_wb_sel,
    input  logic [RADDR_W-1:0]   i_rd,
    input  logic                 i_reg_write,
    output logic [XLEN-1:0]      o_wb_data,
    output logic [RADDR_W-1:0]   o_wb_rd,
    output logic                 o_wb_reg_write,
    output logic                 o_wb_valid,
    output logic [CNT_W-1:0]     o_retire_count
);

    logic                 valid_q;
    logic                 fresh_q;
    logic [XLEN-1:0]      alu_q;
    logic [XLEN-1:0]      rdata_q;
    logic [XLEN-1:0]      pc4_q;
    logic [ADDR_LO_W-1:0] addr_lo_q;
    logic [FUNCT3_W-1:0]  funct3_q;
    logic [WB_SEL_W-1:0]  wb_sel_q;
    logic [RADDR_W-1:0]   rd_q;
    logic                 reg_write_q;
    logic [CNT_W-1:0]     count_q;
    logic [XLEN-1:0]      load_data_c;
    logic                 retire_c;

    // fresh marks the first cycle an instruction sits in WB so a held instruction retires once.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q     <= 1'b0;
            fresh_q     <= 1'b0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc4_q       <= '0;
            addr_lo_q   <= '0;
            funct3_q    <= '0;
            wb_sel_q    <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
            fresh_q <= 1'b0;
        end else if (i_stall) begin
            fresh_q <= 1'b0;
        end else begin
            valid_q     <= i_valid;
            fresh_q     <= 1'b1;
            alu_q       <= i_alu_result;
            rdata_q     <= i_read_data;
            pc4_q       <= i_pc_plus4;
            addr_lo_q   <= i_addr_lo;
            funct3_q    <= i_load_funct3;
            wb_sel_q    <= i_wb_sel;
            rd_q        <= i_rd;
            reg_write_q <= i_reg_write;
        end
    end

    wb_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .word    (rdata_q),
        .data_c  (load_data_c)
    );

    assign retire_c = valid_q & fresh_q;

    // Reserved select code falls back to the ALU result.
    always_comb begin
        o_wb_data = alu_q;
        case (wb_sel_q)
            WB_SEL_MEM: o_wb_data = load_data_c;
            WB_SEL_PC4: o_wb_data = pc4_q;
            default:    o_wb_data = alu_q;
        endcase
    end

    assign o_wb_valid     = retire_c;
    assign o_wb_rd        = rd_q;
    assign o_wb_reg_write = retire_c & reg_write_q & (rd_q != '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else if (retire_c) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign o_retire_count = count_q;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Directed self-checking bench for wb_stage_reg (32-bit, 4-bit counter and 64-bit instances).
module tb_wb_stage_reg;

    logic        clk = 1'b0;
    logic        rst, valid, stall, flush;
    logic [31:0] alu, rdata, pc4;
    logic [63:0] rdata64;
    logic [2:0]  addr_lo, f3;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        rw;

    logic [31:0] wb_data, cnt;
    logic [4:0]  wb_rd;
    logic        wb_rw, wb_valid;

    logic [31:0] d4_data;
    logic [4:0]  d4_rd;
    logic        d4_rw, d4_valid;
    logic [3:0]  d4_cnt;

    logic [63:0] d64_data;
    logic [4:0]  d64_rd;
    logic        d64_rw, d64_valid;
    logic [31:0] d64_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_stage_reg dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_alu_result(alu), .i_read_data(rdata), .i_pc_plus4(pc4), .i_addr_lo(addr_lo),
        .i_load_funct3(f3), .i_wb_sel(sel), .i_rd(rd), .i_reg_write(rw),
        .o_wb_data(wb_data), .o_wb_rd(wb_rd), .o_wb_reg_write(wb_rw),
        .o_wb_valid(wb_valid), .o_retire_count(cnt)
    );

    wb_stage_reg #(.CNT_W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_alu_result(alu), .i_read_data(rdata), .i_pc_plus4(pc4), .i_addr_lo(addr_lo),
        .i_load_funct3(f3), .i_wb_sel(sel), .i_rd(rd), .i_reg_write(rw),
        .o_wb_data(d4_data), .o_wb_rd(d4_rd), .o_wb_reg_write(d4_rw),
        .o_wb_valid(d4_valid), .o_retire_count(d4_cnt)
    );

    wb_stage_reg #(.XLEN(64)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_alu_result({32'b0, alu}), .i_read_data(rdata64), .i_pc_plus4({32'b0, pc4}),
        .i_addr_lo(addr_lo), .i_load_funct3(f3), .i_wb_sel(sel), .i_rd(rd), .i_reg_write(rw),
        .o_wb_data(d64_data), .o_wb_rd(d64_rd), .o_wb_reg_write(d64_rw),
        .o_wb_valid(d64_valid), .o_retire_count(d64_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] s, input logic [2:0] fn, input logic [2:0] a,
                         input logic [31:0] rdv, input logic [31:0] alv, input logic [31:0] pcv,
                         input logic [4:0] r, input logic w);
        valid = 1'b1; sel = s; f3 = fn; addr_lo = a; rdata = rdv; alu = alv; pc4 = pcv;
        rd = r; rw = w;
        tick();
    endtask

    task automatic idle();
        valid = 1'b0; rw = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; stall = 1'b0; flush = 1'b0; alu = '0; rdata = '0; pc4 = '0;
        rdata64 = '0; addr_lo = '0; f3 = '0; sel = '0; rd = '0; rw = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if (wb_data !== 32'h0 || wb_rd !== 5'd0 || wb_rw !== 1'b0 || wb_valid !== 1'b0 || cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: data=%h rd=%0d rw=%b v=%b cnt=%0d, expected all zero", wb_data, wb_rd, wb_rw, wb_valid, cnt);
        end
        issue(2'b00, 3'b010, 3'd0, 32'h0, 32'h1234, 32'h0, 5'd3, 1'b1);
        checks++;
        if (wb_data !== 32'h1234 || wb_rw !== 1'b1 || wb_rd !== 5'd3) begin
            errors++;
            $display("FAIL pre_reset_write: data=%h rw=%b rd=%0d, expected 00001234 1 3", wb_data, wb_rw, wb_rd);
        end
        rst = 1'b1; valid = 1'b0;
        tick();
        rst = 1'b0;
        checks++;
        if (wb_data !== 32'h0 || wb_rd !== 5'd0 || wb_rw !== 1'b0 || wb_valid !== 1'b0 || cnt !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: data=%h rd=%0d rw=%b v=%b cnt=%0d, expected all zero", wb_data, wb_rd, wb_rw, wb_valid, cnt);
        end
    endtask

    task automatic test_loads();
        issue(2'b01, 3'b000, 3'd3, 32'h80FF_0000, 32'hDEAD_0000, 32'h0, 5'd5, 1'b1);
        checks++;
        if (wb_data !== 32'hFFFF_FF80 || wb_rd !== 5'd5 || wb_rw !== 1'b1 || wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL lb: data=%h rd=%0d rw=%b v=%b, expected ffffff80 5 1 1", wb_data, wb_rd, wb_rw, wb_valid);
        end
        idle();
        checks++;
        if (cnt !== 32'd1 || wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL lb_count: cnt=%0d v=%b, expected 1 0", cnt, wb_valid);
        end
        issue(2'b01, 3'b101, 3'd2, 32'hBEEF_1234, 32'h0, 32'h0, 5'd6, 1'b1);
        checks++;
        if (wb_data !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL lhu: data=%h, expected 0000beef", wb_data);
        end
        issue(2'b01, 3'b001, 3'd3, 32'h8001_0000, 32'h0, 32'h0, 5'd7, 1'b1);
        checks++;
        if (wb_data !== 32'hFFFF_8001) begin
            errors++;
            $display("FAIL lh: data=%h, expected ffff8001", wb_data);
        end
        issue(2'b01, 3'b100, 3'd1, 32'h1234_8A78, 32'h0, 32'h0, 5'd8, 1'b1);
        checks++;
        if (wb_data !== 32'h0000_008A) begin
            errors++;
            $display("FAIL lbu: data=%h, expected 0000008a", wb_data);
        end
        issue(2'b01, 3'b010, 3'd4, 32'h9876_5432, 32'h0, 32'h0, 5'd9, 1'b1);
        checks++;
        if (wb_data !== 32'h9876_5432) begin
            errors++;
            $display("FAIL lw32: data=%h, expected 98765432", wb_data);
        end
        idle();
        checks++;
        if (cnt !== 32'd5) begin
            errors++;
            $display("FAIL load_count: cnt=%0d, expected 5", cnt);
        end
    endtask

    task automatic test_sel();
        issue(2'b10, 3'b000, 3'd0, 32'hFFFF_FFFF, 32'h5555_5555, 32'h0000_0104, 5'd1, 1'b1);
        checks++;
        if (wb_data !== 32'h0000_0104 || wb_rd !== 5'd1 || wb_rw !== 1'b1) begin
            errors++;
            $display("FAIL jal: data=%h rd=%0d rw=%b, expected 00000104 1 1", wb_data, wb_rd, wb_rw);
        end
        issue(2'b11, 3'b000, 3'd0, 32'hFFFF_FFFF, 32'hA5A5_0001, 32'h0000_0200, 5'd2, 1'b1);
        checks++;
        if (wb_data !== 32'hA5A5_0001) begin
            errors++;
            $display("FAIL sel_reserved: data=%h, expected a5a50001", wb_data);
        end
        issue(2'b00, 3'b000, 3'd0, 32'h0, 32'h0000_0042, 32'h0, 5'd0, 1'b1);
        checks++;
        if (wb_rw !== 1'b0 || wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL rd0: rw=%b v=%b, expected 0 1", wb_rw, wb_valid);
        end
        idle();
        checks++;
        if (cnt !== 32'd8) begin
            errors++;
            $display("FAIL sel_count: cnt=%0d, expected 8", cnt);
        end
    endtask

    task automatic test_stall();
        issue(2'b00, 3'b000, 3'd0, 32'h0, 32'h0000_0777, 32'h0, 5'd7, 1'b1);
        checks++;
        if (wb_rw !== 1'b1 || wb_data !== 32'h0000_0777) begin
            errors++;
            $display("FAIL stall_capture: rw=%b data=%h, expected 1 00000777", wb_rw, wb_data);
        end
        stall = 1'b1; valid = 1'b1; alu = 32'h0000_0999; rd = 5'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (wb_rw !== 1'b0 || wb_valid !== 1'b0 || wb_rd !== 5'd7 || wb_data !== 32'h0000_0777) begin
                errors++;
                $display("FAIL stall_hold%0d: rw=%b v=%b rd=%0d data=%h, expected 0 0 7 00000777", i, wb_rw, wb_valid, wb_rd, wb_data);
            end
        end
        stall = 1'b0;
        idle();
        checks++;
        if (cnt !== 32'd9) begin
            errors++;
            $display("FAIL stall_count: cnt=%0d, expected 9", cnt);
        end
    endtask

    task automatic test_flush_stall();
        issue(2'b00, 3'b000, 3'd0, 32'h0, 32'h0000_0AAA, 32'h0, 5'd10, 1'b1);
        flush = 1'b1; stall = 1'b1; valid = 1'b1; rd = 5'd11;
        tick();
        flush = 1'b0; stall = 1'b0;
        checks++;
        if (wb_rw !== 1'b0 || wb_valid !== 1'b0 || cnt !== 32'd10) begin
            errors++;
            $display("FAIL flush_stall: rw=%b v=%b cnt=%0d, expected 0 0 10", wb_rw, wb_valid, cnt);
        end
        idle();
        checks++;
        if (cnt !== 32'd10) begin
            errors++;
            $display("FAIL flush_count: cnt=%0d, expected 10", cnt);
        end
    endtask

    task automatic test_xlen64();
        rdata64 = 64'hF123_4567_89AB_CDEF;
        issue(2'b01, 3'b010, 3'd4, 32'h0, 32'h0, 32'h0, 5'd12, 1'b1);
        checks++;
        if (d64_data !== 64'hFFFF_FFFF_F123_4567) begin
            errors++;
            $display("FAIL x64_lw: data=%h, expected fffffffff1234567", d64_data);
        end
        issue(2'b01, 3'b100, 3'd6, 32'h0, 32'h0, 32'h0, 5'd12, 1'b1);
        checks++;
        if (d64_data !== 64'h0000_0000_0000_0023) begin
            errors++;
            $display("FAIL x64_lbu: data=%h, expected 0000000000000023", d64_data);
        end
        issue(2'b01, 3'b011, 3'd5, 32'h0, 32'h0, 32'h0, 5'd12, 1'b1);
        checks++;
        if (d64_data !== 64'hF123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL x64_ld: data=%h, expected f123456789abcdef", d64_data);
        end
        idle();
    endtask

    task automatic test_wrap();
        rst = 1'b1; valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) issue(2'b00, 3'b000, 3'd0, 32'h0, 32'(i), 32'h0, 5'd0, 1'b0);
        idle();
        checks++;
        if (d4_cnt !== 4'hF || cnt !== 32'd15) begin
            errors++;
            $display("FAIL wrap_pre: cnt4=%0d cnt=%0d, expected 15 15", d4_cnt, cnt);
        end
        issue(2'b00, 3'b000, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        idle();
        checks++;
        if (d4_cnt !== 4'h0 || cnt !== 32'd16) begin
            errors++;
            $display("FAIL wrap: cnt4=%0d cnt=%0d, expected 0 16", d4_cnt, cnt);
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_sel();
        test_stall();
        test_flush_stall();
        test_xlen64();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
